// File: rtl/data_table_pkg.sv
// Shared constants and FSM state encoding for the data_table write-side logic.
package data_table_pkg;

    localparam int DT_ADDR_W = 9;
    localparam int DT_DATA_W = 38;
    localparam int DT_DEPTH  = 512;

    // Write engine states. The enum members double as the 2-bit encoding constants.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FIN   = 2'd3
    } wr_state_t;

endpackage

// File: rtl/data_table_wr_ctrl.sv
// Write-side engine for data_table_ram: sweep-clears the whole table or loads a
// burst of words from a valid/ready stream. All RAM write-port signals are registered.
module data_table_wr_ctrl
    import data_table_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DT_ADDR_W,
    parameter int                    DATA_WIDTH = DT_DATA_W,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
    input  logic                  wr_clk,
    input  logic                  tb_wr_rst,
    input  logic                  clr_req,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   wr_count
);

    // Table depth as a count value (one bit wider than an address).
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    wr_state_t               r_state;
    wr_state_t               w_next_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic [ADDR_WIDTH:0]     r_wr_count;
    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_done;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_len_ok;
    logic                    w_start_clear;
    logic                    w_start_load;
    logic                    w_len_err;
    logic                    w_abort_err;
    logic                    w_issue;
    logic [DATA_WIDTH-1:0]   w_issue_data;

    // The stream is only open in LOAD with words still owed; ready never looks at s_valid.
    assign s_ready  = (r_state == ST_LOAD) && (r_remaining != '0);
    assign w_accept = s_valid && s_ready;
    assign w_len_ok = (load_len != '0) && (load_len <= DEPTH_CNT);
    assign busy     = (r_state == ST_CLEAR) || (r_state == ST_LOAD);

    assign ram_wr_en   = r_wr_en;
    assign ram_wr_addr = r_wr_addr;
    assign ram_wr_data = r_wr_data;
    assign done        = r_done;
    assign err         = r_err;
    assign wr_count    = r_wr_count;

    // State register; asynchronous reset returns the engine to IDLE at once.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the per-cycle write/start/error strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next_state  = r_state;
        w_start_clear = 1'b0;
        w_start_load  = 1'b0;
        w_len_err     = 1'b0;
        w_abort_err   = 1'b0;
        w_issue       = 1'b0;
        w_issue_data  = CLEAR_VAL;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_start_clear = 1'b1;
                    w_next_state  = ST_CLEAR;
                end else if (load_req) begin
                    if (w_len_ok) begin
                        w_start_load = 1'b1;
                        w_next_state = ST_LOAD;
                    end else begin
                        w_len_err = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                w_issue = 1'b1;
                if (abort) begin
                    w_abort_err  = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_addr == LAST_ADDR) begin
                    w_next_state = ST_FIN;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_issue      = 1'b1;
                    w_issue_data = s_data;
                end
                if (abort) begin
                    w_abort_err  = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_accept && (r_remaining == {{ADDR_WIDTH{1'b0}}, 1'b1})) begin
                    w_next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Address/length counters, the registered RAM write port and the status pulses.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_wr_count  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_en <= w_issue;
            r_done  <= (r_state == ST_FIN);
            r_err   <= w_len_err || w_abort_err;
            if (w_issue) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_issue_data;
            end
            if (w_start_clear) begin
                r_addr      <= '0;
                r_remaining <= '0;
                r_wr_count  <= '0;
            end else if (w_start_load) begin
                r_addr      <= load_base;
                r_remaining <= load_len;
                r_wr_count  <= '0;
            end else if (w_issue) begin
                // Address wraps naturally at the table end.
                r_addr <= r_addr + 1'b1;
                if (r_state == ST_LOAD) begin
                    r_remaining <= r_remaining - 1'b1;
                end
                if (r_wr_count != DEPTH_CNT) begin
                    r_wr_count <= r_wr_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_table_wr_ctrl.sv
// Bench for data_table_wr_ctrl: a behavioural RAM captures writes, a reference
// model predicts the ordered write list and resulting table contents.
module tb_data_table_wr_ctrl;
    import data_table_pkg::*;

    localparam int AW = DT_ADDR_W;
    localparam int DW = DT_DATA_W;
    localparam int DEPTH = DT_DEPTH;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        int base;
        int len;
        int vmode;   // 0 valid always, 1 toggling, 2 random
        int dmode;   // 0 random data, 1 descending from all-ones
        bit poke;    // pulse clr_req mid-load (must be ignored)
        bit exp_err; // illegal length expected
    } vec_t;

    logic          wr_clk;
    logic          tb_wr_rst;
    logic          clr_req;
    logic          load_req;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_len;
    logic          abort;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   wr_count;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_err = 0;
    wr_t got_q[$];
    wr_t exp_q[$];
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];

    data_table_wr_ctrl dut (
        .wr_clk      (wr_clk),
        .tb_wr_rst   (tb_wr_rst),
        .clr_req     (clr_req),
        .load_req    (load_req),
        .load_base   (load_base),
        .load_len    (load_len),
        .abort       (abort),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .wr_count    (wr_count)
    );

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // Behavioural RAM plus event counters, sampled mid-cycle.
    always @(negedge wr_clk) begin
        if (ram_wr_en === 1'b1) begin
            got_q.push_back('{ram_wr_addr, ram_wr_data});
            mem[ram_wr_addr] = ram_wr_data;
        end
        if (done === 1'b1) n_done++;
        if (err === 1'b1) n_err++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: sim time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Ordered write list against the model, then fold the model into the expected table.
    task automatic compare_writes(input string nm);
        int bad_w;
        bad_w = 0;
        check({nm, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) bad_w++;
        end
        check({nm, "_wseq"}, 64'(bad_w), 64'd0);
        foreach (exp_q[i]) model_mem[exp_q[i].addr] = exp_q[i].data;
    endtask

    task automatic compare_mem(input string nm);
        int bad_m;
        bad_m = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== model_mem[i]) bad_m++;
        check({nm, "_readback"}, 64'(bad_m), 64'd0);
    endtask

    // Full-table clear, optionally with a simultaneous (losing) load_req; checks cycle timing.
    task automatic do_clear(input string nm, input bit with_load);
        int first_c, last_c, nwr, done_c, busy_c, d0;
        first_c = -1; last_c = -1; nwr = 0; done_c = -1; busy_c = 0;
        d0 = n_done;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{AW'(i), '0});
        @(negedge wr_clk);
        clr_req = 1'b1; load_req = with_load; load_base = 9'd3; load_len = 10'd5;
        @(negedge wr_clk);
        clr_req = 1'b0; load_req = 1'b0;
        for (int k = 1; k <= 520; k++) begin
            if (ram_wr_en === 1'b1) begin
                if (first_c < 0) first_c = k;
                last_c = k;
                nwr++;
            end
            if (done === 1'b1 && done_c < 0) done_c = k;
            if (busy === 1'b1) busy_c++;
            @(negedge wr_clk);
        end
        #1;
        check({nm, "_first_wr"}, 64'(first_c), 64'd2);
        check({nm, "_last_wr"}, 64'(last_c), 64'd513);
        check({nm, "_wr_cycles"}, 64'(nwr), 64'd512);
        check({nm, "_done_cycle"}, 64'(done_c), 64'd514);
        check({nm, "_busy_cycles"}, 64'(busy_c), 64'd512);
        check({nm, "_done_once"}, 64'(n_done - d0), 64'd1);
        check({nm, "_wr_count"}, 64'(wr_count), 64'd512);
        compare_writes(nm);
        compare_mem(nm);
    endtask

    // One table/random load vector: drive request, feed beats, check outcome.
    task automatic do_load(input string nm, input vec_t v);
        int sent, cyc, wait_c, d0, e0, busy_seen;
        logic [DW-1:0] beats[$];
        got_q.delete(); exp_q.delete();
        d0 = n_done; e0 = n_err;
        if (!v.exp_err) begin
            for (int i = 0; i < v.len; i++) begin
                logic [DW-1:0] w;
                w = (v.dmode == 1) ? ({DW{1'b1}} - DW'(i)) : rand_word();
                beats.push_back(w);
                exp_q.push_back('{AW'((v.base + i) % DEPTH), w});
            end
        end
        @(negedge wr_clk);
        load_req = 1'b1; load_base = AW'(v.base); load_len = (AW + 1)'(v.len);
        @(negedge wr_clk);
        load_req = 1'b0;
        if (v.exp_err) begin
            check({nm, "_err_pulse"}, 64'(err), 64'd1);
            busy_seen = (busy === 1'b1) ? 1 : 0;
            repeat (4) begin
                @(negedge wr_clk);
                if (busy === 1'b1) busy_seen = 1;
            end
            #1;
            check({nm, "_err_count"}, 64'(n_err - e0), 64'd1);
            check({nm, "_busy_seen"}, 64'(busy_seen), 64'd0);
            check({nm, "_no_writes"}, 64'(got_q.size()), 64'd0);
            check({nm, "_no_done"}, 64'(n_done - d0), 64'd0);
            return;
        end
        sent = 0; cyc = 0;
        while (sent < v.len && cyc < 4 * v.len + 20) begin
            case (v.vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            s_data = s_valid ? beats[sent] : rand_word();
            clr_req = v.poke && (cyc == 2);
            #1;
            if (s_valid && s_ready) sent++;
            @(negedge wr_clk);
            cyc++;
        end
        s_valid = 1'b0; clr_req = 1'b0;
        check({nm, "_beats_sent"}, 64'(sent), 64'(v.len));
        check({nm, "_ready_drop"}, 64'(s_ready), 64'd0);
        wait_c = 0;
        while (n_done == d0 && wait_c < 8) begin
            @(negedge wr_clk);
            #1;
            wait_c++;
        end
        repeat (3) @(negedge wr_clk);
        #1;
        check({nm, "_done_once"}, 64'(n_done - d0), 64'd1);
        check({nm, "_no_err"}, 64'(n_err - e0), 64'd0);
        check({nm, "_wr_count"}, 64'(wr_count), 64'(v.len));
        check({nm, "_busy_end"}, 64'(busy), 64'd0);
        compare_writes(nm);
        compare_mem(nm);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t rv;
        int d0, e0, n;
        int bad_c;

        vecs[0] = '{0,   512, 0, 1, 1'b0, 1'b0};
        vecs[1] = '{510, 4,   0, 0, 1'b0, 1'b0};
        vecs[2] = '{37,  8,   1, 0, 1'b1, 1'b0};
        vecs[3] = '{0,   0,   0, 0, 1'b0, 1'b1};
        vecs[4] = '{5,   513, 0, 0, 1'b0, 1'b1};
        vecs[5] = '{300, 1,   2, 0, 1'b0, 1'b0};
        vecs[6] = '{500, 20,  2, 0, 1'b0, 1'b0};
        vecs[7] = '{511, 2,   1, 0, 1'b0, 1'b0};

        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = rand_word();
            model_mem[i] = mem[i];
        end
        tb_wr_rst = 1'b1; clr_req = 1'b0; load_req = 1'b0; load_base = '0;
        load_len = '0; abort = 1'b0; s_valid = 1'b0; s_data = '0;

        // Reset state.
        #200;
        check("rst_wr_en", 64'(ram_wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        @(negedge wr_clk);
        tb_wr_rst = 1'b0;

        do_clear("clear", 1'b0);

        for (int i = 0; i < 8; i++) do_load($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv = '{int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, 0, 1'b0, 1'b0};
            do_load($sformatf("rnd%0d", i), rv);
        end

        // Abort during LOAD together with a beat: that beat is still written.
        got_q.delete(); exp_q.delete();
        d0 = n_done; e0 = n_err;
        @(negedge wr_clk);
        load_req = 1'b1; load_base = 9'd100; load_len = 10'd20;
        @(negedge wr_clk);
        load_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data = rand_word();
            exp_q.push_back('{AW'(100 + i), s_data});
            abort = (i == 5);
            @(negedge wr_clk);
        end
        s_valid = 1'b0; abort = 1'b0;
        check("abort_err_pulse", 64'(err), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_s_ready", 64'(s_ready), 64'd0);
        repeat (3) @(negedge wr_clk);
        #1;
        check("abort_err_count", 64'(n_err - e0), 64'd1);
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        check("abort_wr_count", 64'(wr_count), 64'd6);
        compare_writes("abort");
        compare_mem("abort");

        // Abort while IDLE is ignored.
        e0 = n_err;
        @(negedge wr_clk);
        abort = 1'b1;
        @(negedge wr_clk);
        abort = 1'b0;
        repeat (3) @(negedge wr_clk);
        #1;
        check("idle_abort_no_err", 64'(n_err - e0), 64'd0);

        // Abort during CLEAR: sweep stops early from address 0 with zero data.
        got_q.delete(); exp_q.delete();
        d0 = n_done; e0 = n_err;
        @(negedge wr_clk);
        clr_req = 1'b1;
        @(negedge wr_clk);
        clr_req = 1'b0;
        repeat (9) @(negedge wr_clk);
        abort = 1'b1;
        @(negedge wr_clk);
        abort = 1'b0;
        check("clr_abort_err_pulse", 64'(err), 64'd1);
        check("clr_abort_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge wr_clk);
        #1;
        n = got_q.size();
        check("clr_abort_nwr_range", 64'((n == 9 || n == 10) ? 1 : 0), 64'd1);
        check("clr_abort_no_done", 64'(n_done - d0), 64'd0);
        check("clr_abort_err_count", 64'(n_err - e0), 64'd1);
        bad_c = 0;
        for (int i = 0; i < n; i++) begin
            if (got_q[i].addr !== AW'(i) || got_q[i].data !== '0) bad_c++;
            model_mem[i] = '0;
        end
        check("clr_abort_wseq", 64'(bad_c), 64'd0);
        compare_mem("clr_abort");

        // Reset mid-LOAD after 5 beats: outputs drop at once, nothing further written.
        got_q.delete(); exp_q.delete();
        d0 = n_done; e0 = n_err;
        @(negedge wr_clk);
        load_req = 1'b1; load_base = 9'd200; load_len = 10'd16;
        @(negedge wr_clk);
        load_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = rand_word();
            exp_q.push_back('{AW'(200 + i), s_data});
            @(negedge wr_clk);
        end
        #2;
        tb_wr_rst = 1'b1;
        #1;
        check("mrst_wr_en", 64'(ram_wr_en), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_s_ready", 64'(s_ready), 64'd0);
        check("mrst_wr_count", 64'(wr_count), 64'd0);
        repeat (4) @(negedge wr_clk);
        s_valid = 1'b0;
        tb_wr_rst = 1'b0;
        repeat (3) @(negedge wr_clk);
        #1;
        check("mrst_no_done", 64'(n_done - d0), 64'd0);
        check("mrst_no_err", 64'(n_err - e0), 64'd0);
        compare_writes("mrst");

        // Fresh clear after reset, with a simultaneous load_req that must be dropped.
        do_clear("clear_and_load", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
